// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants and helper functions for the BCD counter slice.
//   BCD_W          - width of one BCD digit
//   BCD_MAX        - largest legal digit value
//   bcd_to_onehot  - decimal one-hot decode of a single digit
//   bcd_is_valid   - true when a nibble holds a legal BCD digit
package bcd_pkg;

    localparam int       BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [9:0] bcd_to_onehot(input logic [3:0] nib);
        logic [9:0] oh;
        case (nib)
            4'd0:    oh = 10'b00_0000_0001;
            4'd1:    oh = 10'b00_0000_0010;
            4'd2:    oh = 10'b00_0000_0100;
            4'd3:    oh = 10'b00_0000_1000;
            4'd4:    oh = 10'b00_0001_0000;
            4'd5:    oh = 10'b00_0010_0000;
            4'd6:    oh = 10'b00_0100_0000;
            4'd7:    oh = 10'b00_1000_0000;
            4'd8:    oh = 10'b01_0000_0000;
            4'd9:    oh = 10'b10_0000_0000;
            // Unreachable for the counter register; an illegal code decodes to no digit.
            default: oh = 10'b00_0000_0000;
        endcase
        return oh;
    endfunction

    function automatic logic bcd_is_valid(input logic [3:0] nib);
        return (nib <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one decimal digit of the up/down counter.
//   clk, rst  - clock and synchronous active-high reset
//   load      - load request, already qualified as valid by the top level
//   load_nib  - value to load
//   step_in   - count request for this digit (enable or ripple from below)
//   up        - direction, 1 = up
//   nib       - registered digit value, always 0..9
//   step_out  - ripple to the next digit: this digit wraps on this step
module bcd_digit
    import bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [BCD_W-1:0] load_nib,
    input  logic             step_in,
    input  logic             up,
    output logic [BCD_W-1:0] nib,
    output logic             step_out
);

    logic [BCD_W-1:0] nib_r;
    logic [BCD_W-1:0] nib_next_s;
    logic             wrap_s;

    // Next value of the digit when it is stepped, with decimal wrap.
    always_comb begin
        nib_next_s = nib_r;
        wrap_s     = 1'b0;
        if (up) begin
            if (nib_r == BCD_MAX) begin
                nib_next_s = 4'd0;
                wrap_s     = 1'b1;
            end else begin
                nib_next_s = nib_r + 4'd1;
                wrap_s     = 1'b0;
            end
        end else begin
            if (nib_r == 4'd0) begin
                nib_next_s = BCD_MAX;
                wrap_s     = 1'b1;
            end else begin
                nib_next_s = nib_r - 4'd1;
                wrap_s     = 1'b0;
            end
        end
    end

    // Digit register: reset, load, step or hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            nib_r <= 4'd0;
        end else if (load) begin
            nib_r <= load_nib;
        end else if (step_in) begin
            nib_r <= nib_next_s;
        end else begin
            nib_r <= nib_r;
        end
    end

    assign nib      = nib_r;
    assign step_out = step_in & wrap_s;

endmodule

// File: rtl/bcd_dec_counter.sv
// bcd_dec_counter: DIGITS-digit synchronous BCD up/down counter with
// per-digit one-hot decimal decode.
//   clk, rst    - clock and synchronous active-high reset
//   en, up      - count enable and direction (1 = up)
//   load        - parallel load of load_val; rejected if any nibble > 9
//   load_val    - load value, digit d in nibble d
//   bcd         - registered count
//   dec_onehot  - bit 10*d+v set when digit d equals v
//   carry       - one-cycle pulse with the wrapped value (all-0s up / all-9s down)
//   load_err    - one-cycle pulse after a rejected load
module bcd_dec_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_val,
    output logic [4*DIGITS-1:0]     bcd,
    output logic [10*DIGITS-1:0]    dec_onehot,
    output logic                    carry,
    output logic                    load_err
);

    logic [DIGITS:0] step_s;
    logic            all_valid_s;
    logic            load_ok_s;
    logic            carry_r;
    logic            load_err_r;

    // Load is accepted only when every nibble is a legal digit.
    always_comb begin
        all_valid_s = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (!bcd_is_valid(load_val[4*d +: 4])) begin
                all_valid_s = 1'b0;
            end else begin
                all_valid_s = all_valid_s;
            end
        end
    end

    assign load_ok_s = load & all_valid_s;
    // A load request (good or bad) blocks counting in the same cycle.
    assign step_s[0] = en & ~load;

    genvar gd;
    generate
        for (gd = 0; gd < DIGITS; gd++) begin : g_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst      (rst),
                .load     (load_ok_s),
                .load_nib (load_val[4*gd +: 4]),
                .step_in  (step_s[gd]),
                .up       (up),
                .nib      (bcd[4*gd +: 4]),
                .step_out (step_s[gd+1])
            );
            assign dec_onehot[10*gd +: 10] = bcd_to_onehot(bcd[4*gd +: 4]);
        end
    endgenerate

    // Status pulses: ripple out of the top digit means the whole count wrapped.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r    <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            carry_r    <= step_s[DIGITS];
            load_err_r <= load & ~all_valid_s;
        end
    end

    assign carry    = carry_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_dec_counter.sv
// Bench for bcd_dec_counter (DIGITS=2): a decimal-integer model checked every
// cycle plus literal expectations at the interesting points.
module tb_bcd_dec_counter;

    localparam int DIGITS = 2;

    logic        clk = 1'b0;
    logic        rst, en, up, load;
    logic [7:0]  load_val;
    logic [7:0]  bcd;
    logic [19:0] dec_onehot;
    logic        carry, load_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: count as a plain integer 0..99.
    int   m_val = 0;
    logic m_carry = 1'b0;
    logic m_err = 1'b0;
    bit   m_live = 1'b0;

    bcd_dec_counter #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .bcd        (bcd),
        .dec_onehot (dec_onehot),
        .carry      (carry),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic logic [19:0] to_oh(input int v);
        logic [19:0] r;
        r = 20'd0;
        r[v % 10] = 1'b1;
        r[10 + (v / 10)] = 1'b1;
        return r;
    endfunction

    // Model update from the inputs sampled at the rising edge.
    always @(posedge clk) begin
        int hi, lo;
        hi = int'(load_val[7:4]);
        lo = int'(load_val[3:0]);
        if (rst) begin
            m_val = 0; m_carry = 1'b0; m_err = 1'b0; m_live = 1'b1;
        end else if (load) begin
            m_carry = 1'b0;
            if (hi <= 9 && lo <= 9) begin
                m_val = hi * 10 + lo; m_err = 1'b0;
            end else begin
                m_err = 1'b1;
            end
        end else if (en) begin
            m_err = 1'b0;
            if (up) begin
                m_carry = (m_val == 99);
                m_val = (m_val + 1) % 100;
            end else begin
                m_carry = (m_val == 0);
                m_val = (m_val + 99) % 100;
            end
        end else begin
            m_carry = 1'b0; m_err = 1'b0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            cmp("model_bcd",  32'(bcd),        32'(to_bcd(m_val)));
            cmp("model_oh",   32'(dec_onehot), 32'(to_oh(m_val)));
            cmp("model_cy",   32'(carry),      32'(m_carry));
            cmp("model_lerr", 32'(load_err),   32'(m_err));
        end
    end

    // Apply inputs at a falling edge, let one rising edge pass, return at the next falling edge.
    task automatic tick(input logic r, input logic l, input logic [7:0] lv,
                        input logic e, input logic u);
        rst = r; load = l; load_val = lv; en = e; up = u;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
        @(negedge clk);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        cmp("rst_bcd", 32'(bcd), 32'h00);
        cmp("rst_oh",  32'(dec_onehot), 32'h00401);
        cmp("rst_cy",  32'(carry), 32'h0);
        cmp("rst_le",  32'(load_err), 32'h0);

        // Full up sweep 00 -> 99 -> 00.
        for (int i = 1; i <= 99; i++) tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("up_99", 32'(bcd), 32'h99);
        cmp("up_99_cy", 32'(carry), 32'h0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("up_wrap", 32'(bcd), 32'h00);
        cmp("up_wrap_cy", 32'(carry), 32'h1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("up_01", 32'(bcd), 32'h01);
        cmp("up_01_cy", 32'(carry), 32'h0);

        // Down wrap from 00.
        tick(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cmp("dn_wrap", 32'(bcd), 32'h99);
        cmp("dn_wrap_cy", 32'(carry), 32'h1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cmp("dn_98", 32'(bcd), 32'h98);
        cmp("dn_98_cy", 32'(carry), 32'h0);

        // Valid load.
        tick(1'b0, 1'b1, 8'h47, 1'b0, 1'b1);
        cmp("ld_47", 32'(bcd), 32'h47);
        cmp("ld_47_oh", 32'(dec_onehot), 32'h04080);

        // Invalid loads, including back-to-back.
        tick(1'b0, 1'b1, 8'h4A, 1'b0, 1'b1);
        cmp("bad_4A", 32'(bcd), 32'h47);
        cmp("bad_4A_le", 32'(load_err), 32'h1);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        cmp("idle_le", 32'(load_err), 32'h0);
        tick(1'b0, 1'b1, 8'hA4, 1'b1, 1'b1);
        cmp("bad_A4", 32'(bcd), 32'h47);
        cmp("bad_A4_le", 32'(load_err), 32'h1);
        tick(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        cmp("bad_b2b_le", 32'(load_err), 32'h1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("after_bad", 32'(bcd), 32'h48);

        // Priority.
        tick(1'b0, 1'b1, 8'h12, 1'b1, 1'b1);
        cmp("ld_over_en", 32'(bcd), 32'h12);
        tick(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        cmp("rst_over_ld", 32'(bcd), 32'h00);
        cmp("rst_over_ld_cy", 32'(carry), 32'h0);
        cmp("rst_over_ld_le", 32'(load_err), 32'h0);

        // Direction toggle around 09.
        tick(1'b0, 1'b1, 8'h08, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("up_09", 32'(bcd), 32'h09);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cmp("dn_08", 32'(bcd), 32'h08);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("up_10", 32'(bcd), 32'h10);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cmp("dn_09", 32'(bcd), 32'h09);

        // Mid-count reset.
        tick(1'b0, 1'b1, 8'h36, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("up_37", 32'(bcd), 32'h37);
        tick(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        cmp("mid_rst", 32'(bcd), 32'h00);
        cmp("mid_rst_oh", 32'(dec_onehot), 32'h00401);
        tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
